// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lm_sm_sequencer
// Purpose : Load-multiple / store-multiple transfer engine. It walks a register
//           bitmap from the lowest set bit upward, moving one word per set bit
//           at consecutive memory addresses over a req/ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
module lm_sm_sequencer #(
   parameter int NREG      = 8,
   parameter int DW        = 16,
   parameter int AW        = 16,
   parameter int ADDR_STEP = 1,
   parameter int IDXW      = $clog2(NREG),
   parameter int CNTW      = $clog2(NREG + 1)
) (
   input  logic            clk,
   input  logic            proc_rst,
   input  logic            start,
   input  logic            is_store,
   input  logic [NREG-1:0] reg_list,
   input  logic [AW-1:0]   base_addr,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] xfer_count,
   output logic [AW-1:0]   final_addr,
   output logic [IDXW-1:0] rf_raddr,
   input  logic [DW-1:0]   rf_rdata,
   output logic            rf_wen,
   output logic [IDXW-1:0] rf_waddr,
   output logic [DW-1:0]   rf_wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_pending_clr;
   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   r_final_addr;
   logic            r_store;
   logic [CNTW-1:0] r_count;
   logic [IDXW-1:0] r_wb_idx;
   logic [DW-1:0]   r_wb_data;
   logic [IDXW-1:0] w_idx;

   // Priority encoder: the lowest pending register is always served first.
   always_comb begin
      w_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_idx = IDXW'(i);
         end
      end
   end

   assign w_pending_clr = r_pending & ~(NREG'(1) << w_idx);

   always_ff @(posedge clk) begin
      if (proc_rst) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_addr       <= '0;
         r_final_addr <= '0;
         r_store      <= 1'b0;
         r_count      <= '0;
         r_wb_idx     <= '0;
         r_wb_data    <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pending <= reg_list;
                  r_addr    <= base_addr;
                  r_store   <= is_store;
                  r_count   <= '0;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  r_pending <= w_pending_clr;
                  r_addr    <= r_addr + AW'(ADDR_STEP);
                  r_count   <= r_count + CNTW'(1);
                  if (!r_store) begin
                     r_wb_idx  <= w_idx;
                     r_wb_data <= mem_rdata;
                  end
               end
            end
            S_DONE: begin
               r_final_addr <= r_addr;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      rf_wen       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (reg_list == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = r_store;
            mem_wdata = rf_rdata;
            if (mem_ack) begin
               if (!r_store) begin
                  w_state_next = S_WB;
               end else if (w_pending_clr == '0) begin
                  w_state_next = S_DONE;
               end
            end
         end
         S_WB: begin
            busy         = 1'b1;
            rf_wen       = 1'b1;
            w_state_next = (r_pending == '0) ? S_DONE : S_REQ;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign xfer_count = r_count;
   // The address register already holds the post-transfer address in DONE.
   assign final_addr = (r_state == S_DONE) ? r_addr : r_final_addr;
   assign mem_addr   = r_addr;
   assign rf_raddr   = w_idx;
   assign rf_waddr   = r_wb_idx;
   assign rf_wdata   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lm_sm_sequencer
// Purpose : Self-checking bench: memory/RF responder plus a transfer-list model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lm_sm_sequencer;
   localparam int NREG = 16;
   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int IDXW = 4;
   localparam int CNTW = 5;

   logic            clk = 1'b0;
   logic            proc_rst = 1'b1;
   logic            start = 1'b0;
   logic            is_store = 1'b0;
   logic [NREG-1:0] reg_list = '0;
   logic [AW-1:0]   base_addr = '0;
   logic            busy, done, rf_wen, mem_req, mem_we;
   logic [CNTW-1:0] xfer_count;
   logic [AW-1:0]   final_addr, mem_addr;
   logic [IDXW-1:0] rf_raddr, rf_waddr;
   logic [DW-1:0]   rf_rdata, rf_wdata, mem_wdata;
   logic [DW-1:0]   mem_rdata = '0;
   logic            mem_ack = 1'b0;

   lm_sm_sequencer #(.NREG(NREG), .DW(DW), .AW(AW), .ADDR_STEP(1)) dut (
      .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
      .reg_list(reg_list), .base_addr(base_addr), .busy(busy), .done(done),
      .xfer_count(xfer_count), .final_addr(final_addr), .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDXW-1:0] idx;
      logic [15:0]     val;
   } item_t;

   item_t         exp_q[$];   // outstanding transfers: register index + address
   item_t         wb_q[$];    // loaded words awaiting register writeback
   logic [DW-1:0] mem_m [0:65535];
   logic [DW-1:0] rf_m  [0:NREG-1];
   int            vectors = 0, errors = 0, cyc = 0;
   int            ack_delay = 0, wait_cnt = 0, exp_count = 0, exp_done_cyc = 0;
   logic          exp_store = 1'b0, op_active = 1'b0, stray_ack = 1'b0;
   logic [AW-1:0] exp_final = '0;
   logic          m_req, m_wb, m_done;

   assign rf_rdata = rf_m[rf_raddr];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder and per-cycle compare against the transfer-list model.
   always @(negedge clk) begin
      if (mem_req) begin
         mem_ack  = (wait_cnt >= ack_delay);
         wait_cnt = mem_ack ? 0 : wait_cnt + 1;
      end else begin
         mem_ack  = stray_ack;
         wait_cnt = 0;
      end
      mem_rdata = mem_m[mem_addr];
      if (!proc_rst) begin
         m_wb   = (wb_q.size() != 0);
         m_req  = (exp_q.size() != 0) && !m_wb;
         m_done = op_active && !m_req && !m_wb;
         check("busy", busy, m_req || m_wb);
         check("mem_req", mem_req, m_req);
         check("mem_we", mem_we, m_req && exp_store);
         check("rf_wen", rf_wen, m_wb);
         check("done", done, m_done);
         check("xfer_count", xfer_count, exp_count - exp_q.size());
         if (!op_active || m_done) check("final_addr", final_addr, exp_final);
         if (m_req) begin
            check("mem_addr", mem_addr, exp_q[0].val);
            check("rf_raddr", rf_raddr, exp_q[0].idx);
            if (exp_store) check("mem_wdata", mem_wdata, rf_m[exp_q[0].idx]);
            if (mem_ack && mem_req) begin
               if (exp_store) mem_m[exp_q[0].val] = mem_wdata;
               else wb_q.push_back('{idx: exp_q[0].idx, val: mem_m[exp_q[0].val]});
               void'(exp_q.pop_front());
            end
         end else if (m_wb) begin
            check("rf_waddr", rf_waddr, wb_q[0].idx);
            check("rf_wdata", rf_wdata, wb_q[0].val);
            rf_m[wb_q[0].idx] = rf_wdata;
            void'(wb_q.pop_front());
         end else if (m_done) begin
            check("done_latency", cyc, exp_done_cyc);
            op_active = 1'b0;
         end
      end
   end

   // Called just after a rising edge; start is sampled on the following edge.
   task automatic start_op(input logic [NREG-1:0] list, input logic [AW-1:0] base,
                           input logic st, input int d, input logic stray);
      int n;
      int lat;
      ack_delay = d;
      stray_ack = stray;
      start     = 1'b1;
      reg_list  = list;
      base_addr = base;
      is_store  = st;
      @(posedge clk); #1;
      start     = 1'b0;
      reg_list  = ~list;
      base_addr = ~base;
      is_store  = ~st;
      n = 0;
      exp_q.delete();
      wb_q.delete();
      for (int i = 0; i < NREG; i++) begin
         if (list[i]) begin
            exp_q.push_back('{idx: IDXW'(i), val: base + AW'(n)});
            n++;
         end
      end
      exp_count    = n;
      exp_final    = base + AW'(n);
      exp_store    = st;
      lat          = n * (1 + d) + (st ? 0 : n) + 1;
      exp_done_cyc = cyc + lat - 1;
      op_active    = 1'b1;
   endtask

   task automatic wait_done(input logic intrude);
      int t;
      t = 0;
      while (op_active && t < 400) begin
         @(posedge clk); #1;
         t++;
         if (intrude) begin
            start     = (busy && t == 2) || done;
            reg_list  = 16'hFFFF;
            base_addr = 16'h0700;
            is_store  = ~exp_store;
         end
      end
      start = 1'b0;
      check("op_completed", op_active, 0);
      if (op_active) begin
         op_active = 1'b0;
         exp_q.delete();
         wb_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rf_wen"}, rf_wen, 0);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_xfer_count"}, xfer_count, 0);
      check({tag, "_final_addr"}, final_addr, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 65536; a++) mem_m[a] = DW'(a) ^ 16'h5A5A;
      mem_m[16'h0040] = 16'hAAAA;
      mem_m[16'h0041] = 16'hBBBB;
      mem_m[16'h0042] = 16'hCCCC;
      for (int i = 0; i < NREG; i++) rf_m[i] = 16'h1000 + DW'(i);

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      proc_rst = 1'b0;
      @(posedge clk); #1;

      // LM, immediate ack
      start_op(16'h0085, 16'h0040, 1'b0, 0, 1'b0);
      wait_done(1'b0);
      check("t1_r0", rf_m[0], 16'hAAAA);
      check("t1_r2", rf_m[2], 16'hBBBB);
      check("t1_r7", rf_m[7], 16'hCCCC);
      check("t1_count", xfer_count, 3);
      check("t1_final", final_addr, 16'h0043);

      // SM, two wait states per transfer
      start_op(16'h0018, 16'h0100, 1'b1, 2, 1'b0);
      wait_done(1'b0);
      check("t2_mem100", mem_m[16'h0100], 16'h1003);
      check("t2_mem101", mem_m[16'h0101], 16'h1004);
      check("t2_count", xfer_count, 2);

      // Empty list
      start_op(16'h0000, 16'h0123, 1'b1, 0, 1'b0);
      wait_done(1'b0);
      check("t3_count", xfer_count, 0);
      check("t3_final", final_addr, 16'h0123);

      // Full 16-register store across the address wrap
      start_op(16'hFFFF, 16'hFFFE, 1'b1, 0, 1'b0);
      wait_done(1'b0);
      check("t6_memFFFE", mem_m[16'hFFFE], 16'hAAAA);
      check("t6_memFFFF", mem_m[16'hFFFF], 16'h1001);
      check("t6_mem0000", mem_m[16'h0000], 16'hBBBB);
      check("t6_mem000D", mem_m[16'h000D], 16'h100F);
      check("t6_count", xfer_count, 16);
      check("t6_final", final_addr, 16'h000E);

      // Start pulses while busy and in DONE must be ignored
      start_op(16'h0021, 16'h0500, 1'b1, 1, 1'b0);
      wait_done(1'b1);
      check("t5_mem500", mem_m[16'h0500], 16'hAAAA);
      check("t5_mem501", mem_m[16'h0501], 16'h1005);
      check("t5_count", xfer_count, 2);
      check("t5_final", final_addr, 16'h0502);
      repeat (4) @(posedge clk);
      #1;
      check("t5_idle_busy", busy, 0);
      check("t5_idle_count", xfer_count, 2);

      // LM with one wait state and acks asserted outside of requests
      start_op(16'h4008, 16'h0300, 1'b0, 1, 1'b1);
      wait_done(1'b0);
      stray_ack = 1'b0;
      check("t7_r3", rf_m[3], 16'h595A);
      check("t7_r14", rf_m[14], 16'h595B);

      // Reset during writeback aborts the load
      start_op(16'h0006, 16'h0200, 1'b0, 0, 1'b0);
      for (int t = 0; t < 20 && !rf_wen; t++) begin
         @(posedge clk); #1;
      end
      check("t4_in_wb", rf_wen, 1);
      proc_rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      wb_q.delete();
      op_active = 1'b0;
      exp_count = 0;
      exp_final = '0;
      proc_rst  = 1'b0;
      check_reset_outputs("t4_after_reset");
      repeat (3) @(posedge clk);
      #1;
      start_op(16'h0006, 16'h0200, 1'b0, 0, 1'b0);
      wait_done(1'b0);
      check("t4_r1", rf_m[1], 16'h585A);
      check("t4_r2", rf_m[2], 16'h585B);
      check("t4_count", xfer_count, 2);
      check("t4_final", final_addr, 16'h0202);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire
